// File: rtl/shift_reg_ctrl.sv
// Sequencer for an external parallel-load / serial-out shift register.
// Words arrive over valid/ready into a one-entry buffer and leave MSB-first on sout.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             carga,
    output logic             shift,
    output logic [WIDTH-1:0] cargaData,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             start_ok;
    logic             accept;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on the buffer flop, never on in_valid.
    assign in_ready  = ~buf_full_q;
    assign cargaData = buf_q;
    assign busy      = (state_q != S_IDLE) || buf_full_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        carga      = 1'b0;
        shift      = 1'b0;
        bit_valid  = 1'b0;
        bit_last   = 1'b0;
        start_ok   = buf_full_q && enable;
        accept     = in_valid && !buf_full_q;

        if (accept) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                carga      = 1'b1;
                buf_full_d = 1'b0;
                bit_cnt_d  = '0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                bit_valid = 1'b1;
                if (bit_cnt_q != LAST_BIT) begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    bit_last = 1'b1;
                    // Reloading on the LSB cycle keeps the serial stream gap-free.
                    if (GAP == 0 && start_ok) begin
                        carga      = 1'b1;
                        buf_full_d = 1'b0;
                        bit_cnt_d  = '0;
                    end else if (GAP > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = start_ok ? S_LOAD : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl: one instance with no inter-word gap, one with GAP=2,
// each feeding a behavioural shift register so sout can be observed.
module tb_shift_reg_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       sel = 1'b0;

    logic       o0_ready, o0_carga, o0_shift, o0_bv, o0_bl, o0_busy;
    logic [7:0] o0_cd;
    logic [1:0] o0_st;
    logic       o2_ready, o2_carga, o2_shift, o2_bv, o2_bl, o2_busy;
    logic [7:0] o2_cd;
    logic [1:0] o2_st;

    shift_reg_ctrl #(.WIDTH(8), .GAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(o0_ready), .carga(o0_carga), .shift(o0_shift), .cargaData(o0_cd),
        .bit_valid(o0_bv), .bit_last(o0_bl), .busy(o0_busy), .dbg_state(o0_st)
    );

    shift_reg_ctrl #(.WIDTH(8), .GAP(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(o2_ready), .carga(o2_carga), .shift(o2_shift), .cargaData(o2_cd),
        .bit_valid(o2_bv), .bit_last(o2_bl), .busy(o2_busy), .dbg_state(o2_st)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // external shift register models
    logic [7:0] sreg0 = 8'h00;
    logic [7:0] sreg2 = 8'h00;
    always @(posedge clk) begin
        if (o0_carga) sreg0 <= o0_cd;
        else if (o0_shift) sreg0 <= {sreg0[6:0], 1'b0};
        if (o2_carga) sreg2 <= o2_cd;
        else if (o2_shift) sreg2 <= {sreg2[6:0], 1'b0};
    end

    logic       m_ready, m_carga, m_shift, m_bv, m_bl, m_busy, m_sout;
    logic [7:0] m_cd;
    assign m_ready = sel ? o2_ready : o0_ready;
    assign m_carga = sel ? o2_carga : o0_carga;
    assign m_shift = sel ? o2_shift : o0_shift;
    assign m_bv    = sel ? o2_bv : o0_bv;
    assign m_bl    = sel ? o2_bl : o0_bl;
    assign m_busy  = sel ? o2_busy : o0_busy;
    assign m_cd    = sel ? o2_cd : o0_cd;
    assign m_sout  = sel ? sreg2[7] : sreg0[7];

    // scoreboard capture
    int         carga_cyc_q[$];
    logic [7:0] cd_q[$];
    logic       bit_q[$];
    int         bitcyc_q[$];
    int         last_cyc_q[$];
    logic [7:0] acc_q[$];
    int         acc_cyc_q[$];
    logic       hist_rdy[1024];
    logic       hist_strobe[1024];
    int         shift_n = 0;
    int         both_n = 0;

    always @(negedge clk) begin
        hist_rdy[cyc % 1024]    = m_ready;
        hist_strobe[cyc % 1024] = m_carga | m_shift;
        if (m_carga) begin
            carga_cyc_q.push_back(cyc);
            cd_q.push_back(m_cd);
        end
        if (m_shift) shift_n++;
        if (o0_carga && o0_shift) both_n++;
        if (o2_carga && o2_shift) both_n++;
        if (m_bv) begin
            bit_q.push_back(m_sout);
            bitcyc_q.push_back(cyc);
        end
        if (m_bl) last_cyc_q.push_back(cyc);
        if (in_valid && m_ready) begin
            acc_q.push_back(in_data);
            acc_cyc_q.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_bits();
        logic [31:0] v = 32'h0;
        foreach (bit_q[i]) v = {v[30:0], bit_q[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_bytes(input logic [7:0] q[$]);
        logic [31:0] v = 32'h0;
        foreach (q[i]) v = {v[23:0], q[i]};
        return v;
    endfunction

    // driver tasks
    task automatic clear_mon();
        carga_cyc_q.delete(); cd_q.delete(); bit_q.delete(); bitcyc_q.delete();
        last_cyc_q.delete(); acc_q.delete(); acc_cyc_q.delete();
        shift_n = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_mon();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("send_accepted", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int en_cyc;
        int stalls;
        int idx;
        bit hit;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_carga", {31'b0, o0_carga}, 32'd0);
        check_eq("rst_shift", {31'b0, o0_shift}, 32'd0);
        check_eq("rst_cargaData", {24'b0, o0_cd}, 32'd0);
        check_eq("rst_bit_valid", {31'b0, o0_bv}, 32'd0);
        check_eq("rst_bit_last", {31'b0, o0_bl}, 32'd0);
        check_eq("rst_busy", {31'b0, o0_busy}, 32'd0);
        check_eq("rst_in_ready", {31'b0, o0_ready}, 32'd1);
        reset = 1'b1;

        // single word
        sel = 1'b0;
        do_reset();
        send(8'hAA);
        wait_cycles(14);
        check_eq("t1_carga_n", carga_cyc_q.size(), 32'd1);
        check_eq("t1_cargaData", {24'b0, cd_q[0]}, 32'hAA);
        check_eq("t1_carga_lat", carga_cyc_q[0] - acc_cyc_q[0], 32'd2);
        check_eq("t1_nbits", bit_q.size(), 32'd8);
        check_eq("t1_bits", pack_bits(), 32'hAA);
        check_eq("t1_first_bit_lat", bitcyc_q[0] - acc_cyc_q[0], 32'd3);
        check_eq("t1_bit_last_cyc", last_cyc_q[0], acc_cyc_q[0] + 10);
        check_eq("t1_shift_n", shift_n, 32'd7);
        check_eq("t1_busy_end", {31'b0, o0_busy}, 32'd0);
        check_eq("t1_ready_end", {31'b0, o0_ready}, 32'd1);

        // back-to-back
        do_reset();
        send(8'hAA);
        send(8'hCC);
        wait_cycles(25);
        check_eq("t2_nbits", bit_q.size(), 32'd16);
        check_eq("t2_bits", pack_bits(), 32'hAACC);
        check_eq("t2_contiguous", bitcyc_q[15] - bitcyc_q[0], 32'd15);
        check_eq("t2_carga_n", carga_cyc_q.size(), 32'd2);
        check_eq("t2_carga_on_last", carga_cyc_q[1], last_cyc_q[0]);
        check_eq("t2_cargaData2", {24'b0, cd_q[1]}, 32'hCC);
        cnt = 0;
        for (int k = acc_cyc_q[1] + 1; k <= carga_cyc_q[1]; k++)
            if (hist_rdy[k % 1024] == 1'b0) cnt++;
        check_eq("t2_ready_low_n", cnt, carga_cyc_q[1] - acc_cyc_q[1]);
        check_eq("t2_ready_after", {31'b0, hist_rdy[(carga_cyc_q[1] + 1) % 1024]}, 32'd1);

        // inter-word gap
        sel = 1'b1;
        do_reset();
        send(8'hF0);
        send(8'h0F);
        wait_cycles(30);
        check_eq("t3_nbits", bit_q.size(), 32'd16);
        check_eq("t3_bits", pack_bits(), 32'hF00F);
        check_eq("t3_period", carga_cyc_q[1] - carga_cyc_q[0], 32'd11);
        check_eq("t3_last_to_carga", carga_cyc_q[1] - last_cyc_q[0], 32'd3);
        cnt = 0;
        for (int k = last_cyc_q[0] + 1; k < carga_cyc_q[1]; k++)
            if (hist_strobe[k % 1024]) cnt++;
        check_eq("t3_gap_strobes", cnt, 32'd0);
        check_eq("t3_busy_end", {31'b0, o2_busy}, 32'd0);

        // enable hold
        sel = 1'b0;
        do_reset();
        enable = 1'b0;
        send(8'h55);
        wait_cycles(20);
        check_eq("t4_no_carga", carga_cyc_q.size(), 32'd0);
        check_eq("t4_ready_low", {31'b0, o0_ready}, 32'd0);
        check_eq("t4_busy_held", {31'b0, o0_busy}, 32'd1);
        enable = 1'b1;
        en_cyc = cyc;
        wait_cycles(14);
        check_eq("t4_carga_cyc", carga_cyc_q[0], en_cyc + 1);
        check_eq("t4_cargaData", {24'b0, cd_q[0]}, 32'h55);
        check_eq("t4_bits", pack_bits(), 32'h55);

        // reset mid-word
        do_reset();
        send(8'hC3);
        send(8'h3C);
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (bit_q.size() == 4) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("t5_reached_bit3", {31'b0, hit}, 32'd1);
        check_eq("t5_buffered", acc_q.size(), 32'd2);
        check_eq("t5_bits_before", pack_bits(), 32'hC);
        reset = 1'b0;
        #1;
        check_eq("t5_carga", {31'b0, o0_carga}, 32'd0);
        check_eq("t5_shift", {31'b0, o0_shift}, 32'd0);
        check_eq("t5_bit_valid", {31'b0, o0_bv}, 32'd0);
        check_eq("t5_in_ready", {31'b0, o0_ready}, 32'd1);
        check_eq("t5_busy", {31'b0, o0_busy}, 32'd0);
        #1;
        reset = 1'b1;
        clear_mon();
        wait_cycles(20);
        check_eq("t5_no_carga_after", carga_cyc_q.size(), 32'd0);
        check_eq("t5_no_bits_after", bit_q.size(), 32'd0);

        // handshake stall with in_valid held high
        do_reset();
        idx = 0;
        stalls = 0;
        in_data = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && idx < 3; i++) begin
            @(negedge clk);
            if (m_ready) begin
                @(posedge clk); #1;
                idx++;
                in_data = 8'(idx + 1);
                if (idx == 3) in_valid = 1'b0;
            end else begin
                stalls++;
            end
        end
        in_valid = 1'b0;
        wait_cycles(40);
        check_eq("t6_words_sent", idx, 32'd3);
        check_eq("t6_stalled", {31'b0, stalls > 0}, 32'd1);
        check_eq("t6_acc_n", acc_q.size(), 32'd3);
        check_eq("t6_acc_order", pack_bytes(acc_q), 32'h010203);
        check_eq("t6_carga_n", carga_cyc_q.size(), 32'd3);
        check_eq("t6_cargaData_seq", pack_bytes(cd_q), 32'h010203);
        check_eq("t6_bits", pack_bits(), 32'h010203);
        check_eq("t6_contiguous", bitcyc_q[23] - bitcyc_q[0], 32'd23);

        check_eq("carga_shift_exclusive", both_n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
